axi4_cmd_arbiter: RTL and testbench
===================================

AXI4_CMD_ARBITER -- requirements
Module: axi4_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester command valid.
REQ-006 SHALL have port req_ready  out  NUM_REQ  per-requester command accepted.
REQ-007 SHALL have port req_dir  in  NUM_REQ  AXI4_DIR_READ/AXI4_DIR_WRITE per requester.
REQ-008 SHALL have port req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses, requester i at slice i.
REQ-009 SHALL have port req_len  in  NUM_REQ*8  packed AXI4 burst lengths (beats-1).
REQ-010 SHALL have port req_done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port req_msgs  out  axi4_master_msgs_t  completion status, valid when any req_done bit is high.
REQ-012 SHALL have ports mst_valid/mst_dir/mst_addr/mst_len  out  1/1/ADDR_WIDTH/8  command to the shared AXI4 master.
REQ-013 SHALL have port mst_ready  in  1  master command accept.
REQ-014 SHALL have ports mst_done/mst_msgs  in  1/axi4_master_msgs_t  master completion pulse and status.
REQ-015 SHALL have port grant_id  out  $clog2(NUM_REQ)  index of current owner.

Function
REQ-016 SHALL implement states ST_ARB_IDLE, ST_ARB_ISSUE, ST_ARB_BUSY.
REQ-017 In IDLE with any req_valid set, SHALL select a winner by round-robin starting at (last_grant+1) mod NUM_REQ, register winner's dir/addr/len and grant_id, go to ISSUE next cycle.
REQ-018 In ISSUE, mst_valid SHALL be 1 with the registered command held stable; on mst_valid&&mst_ready SHALL pulse req_ready[grant_id] for exactly that cycle, deassert mst_valid, go to BUSY.
REQ-019 In BUSY, on mst_done SHALL pulse req_done[grant_id] and drive req_msgs=mst_msgs in the same cycle (combinational pass-through), update last_grant=grant_id, return to IDLE.
REQ-020 Arbitration latency SHALL be 1 cycle (req_valid to mst_valid); back-to-back grants SHALL have at most one IDLE cycle between mst_done and next mst_valid.
REQ-021 Requester SHALL hold req_valid and its command until req_ready; arbiter SHALL not sample a requester's fields after registering them.
REQ-022 mst_done outside BUSY SHALL be ignored; req_done SHALL never pulse outside BUSY.
REQ-023 A requester dropping req_valid while in ISSUE SHALL not cancel the issued command (AXI no-retraction).
REQ-024 Only one outstanding transaction SHALL exist; req_ready and req_done SHALL be one-hot or zero.
REQ-025 last_grant wrap: after NUM_REQ-1 the search SHALL wrap to 0.

Reset
REQ-026 On rst: state IDLE, mst_valid 0, req_ready 0, req_done 0, req_msgs 0, grant_id 0, last_grant NUM_REQ-1 (so requester 0 wins first), registered command 0.
REQ-027 rst mid-transaction SHALL abandon it with no req_done pulse; recovery of the external master is out of scope.

Configuration
REQ-028 Macro AXI_ARB_WRITE_PRIO_EN defined: in IDLE, if any valid requester has dir=AXI4_DIR_WRITE, SHALL restrict round-robin to write requesters only; undefined: pure round-robin ignoring direction.

Structure
REQ-029 State enum st_axi4_arb_t SHALL reside in axi_lib_pkg; AXI4_DIR_* and axi4_master_msgs_t SHALL be reused from it.
REQ-030 Round-robin selection SHALL be a sub-module axi_rr_select (request vector, pointer, mask -> one-hot/index, valid), combinational.

Verification
REQ-031 Reset then req_valid=2'b11 -> requester 0 granted first, mst_addr=req_addr[0], then requester 1 after mst_done.
REQ-032 Requester 1 continuously valid, requester 0 pulses -> grants alternate 0,1,0,1; no requester waits >1 grant.
REQ-033 mst_ready held 0 for 5 cycles -> mst_valid and command stable all 5 cycles; req_ready pulses once on accept.
REQ-034 mst_done with mst_msgs.wresp=AXI4_RESP_SLVERR -> req_done[grant_id]=1 and req_msgs.wresp=2'b10 same cycle.
REQ-035 With AXI_ARB_WRITE_PRIO_EN: req0 read, req1 write both valid, last_grant=1 -> requester 1 granted; without macro -> requester 0.
REQ-036 rst asserted in BUSY -> next cycle IDLE, all outputs 0, later mst_done produces no req_done.

Source files
------------

// File: rtl/axi_lib_pkg.sv
// Shared AXI4 library types: direction codes, response codes, the
// master completion status and the command-arbiter state encoding.
package axi_lib_pkg;

  localparam logic AXI4_DIR_READ  = 1'b0;
  localparam logic AXI4_DIR_WRITE = 1'b1;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  // Completion status reported by the shared master for one burst.
  typedef struct packed {
    logic [1:0] rresp;
    logic [1:0] wresp;
  } axi4_master_msgs_t;

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_ISSUE = 2'd1,
    ST_ARB_BUSY  = 2'd2
  } st_axi4_arb_t;

endpackage

// File: rtl/axi_rr_select.sv
// Combinational round-robin picker: searches (req & mask) starting one
// past ptr, wrapping at N-1 back to 0. Returns one-hot, index and valid.
module axi_rr_select #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [N-1:0] elig;
  assign elig = req & mask;

  // First eligible requester at or after ptr+1 (mod N) wins.
  always_comb begin
    int j;
    j          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + 1 + i) % N;
      if (!gnt_valid && elig[j]) begin
        gnt_valid     = 1'b1;
        gnt_idx       = IW'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4 command master between NUM_REQ
// requesters with a single outstanding transaction.
// Optional macro AXI_ARB_WRITE_PRIO_EN: when any valid requester is a
// write, only write requesters take part in the round-robin.
module axi4_cmd_arbiter
  import axi_lib_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_dir,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            req_done,
  output axi4_master_msgs_t             req_msgs,
  output logic                          mst_valid,
  output logic                          mst_dir,
  output logic [ADDR_WIDTH-1:0]         mst_addr,
  output logic [7:0]                    mst_len,
  input  logic                          mst_ready,
  input  logic                          mst_done,
  input  axi4_master_msgs_t             mst_msgs,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IW = $clog2(NUM_REQ);

  st_axi4_arb_t            state, state_d;
  logic [IW-1:0]           grant_q, last_q;
  logic [NUM_REQ-1:0]      grant_oh_q;
  logic                    cmd_dir_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [7:0]              cmd_len_q;

  logic [NUM_REQ-1:0]      sel_mask, sel_oh;
  logic [IW-1:0]           sel_idx;
  logic                    sel_valid;

`ifdef AXI_ARB_WRITE_PRIO_EN
  logic [NUM_REQ-1:0]      wr_req;
  // Writes pending anywhere shut reads out of this arbitration round.
  always_comb begin
    wr_req = '0;
    for (int i = 0; i < NUM_REQ; i++)
      wr_req[i] = req_valid[i] && (req_dir[i] == AXI4_DIR_WRITE);
    sel_mask = (|wr_req) ? wr_req : '1;
  end
`else
  assign sel_mask = '1;
`endif

  axi_rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .req        (req_valid),
    .ptr        (last_q),
    .mask       (sel_mask),
    .gnt_onehot (sel_oh),
    .gnt_idx    (sel_idx),
    .gnt_valid  (sel_valid)
  );

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_ARB_IDLE:  if (sel_valid) state_d = ST_ARB_ISSUE;
      ST_ARB_ISSUE: if (mst_ready) state_d = ST_ARB_BUSY;
      ST_ARB_BUSY:  if (mst_done)  state_d = ST_ARB_IDLE;
      default:      state_d = ST_ARB_IDLE;
    endcase
  end

  // State, captured winner command and round-robin pointer. The command is
  // captured once in IDLE and never re-sampled, so requester inputs may
  // change freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      cmd_dir_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
    end else begin
      state <= state_d;
      if (state == ST_ARB_IDLE && sel_valid) begin
        grant_q    <= sel_idx;
        grant_oh_q <= sel_oh;
        cmd_dir_q  <= req_dir[sel_idx];
        cmd_addr_q <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_len_q  <= req_len[sel_idx*8 +: 8];
      end
      if (state == ST_ARB_BUSY && mst_done)
        last_q <= grant_q;
    end
  end

  // Handshake pulses and status pass-through, all gated by state so stray
  // master completions outside BUSY are dropped.
  always_comb begin
    mst_valid = (state == ST_ARB_ISSUE);
    req_ready = (state == ST_ARB_ISSUE && mst_ready) ? grant_oh_q : '0;
    req_done  = (state == ST_ARB_BUSY  && mst_done)  ? grant_oh_q : '0;
    req_msgs  = (state == ST_ARB_BUSY  && mst_done)  ? mst_msgs   : '0;
  end

  assign mst_dir  = cmd_dir_q;
  assign mst_addr = cmd_addr_q;
  assign mst_len  = cmd_len_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_axi4_cmd_arbiter.sv
// Bench for axi4_cmd_arbiter: table of arbitration rounds with a grant
// scoreboard, plus hand sequences for reset-in-BUSY and stray completions.
module tb_axi4_cmd_arbiter;
  import axi_lib_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_dir, req_done;
  logic [N*AW-1:0]   req_addr;
  logic [N*8-1:0]    req_len;
  axi4_master_msgs_t req_msgs, mst_msgs;
  logic              mst_valid, mst_dir, mst_ready, mst_done;
  logic [AW-1:0]     mst_addr;
  logic [7:0]        mst_len;
  logic [0:0]        grant_id;

  axi4_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_len(req_len), .req_done(req_done),
    .req_msgs(req_msgs), .mst_valid(mst_valid), .mst_dir(mst_dir),
    .mst_addr(mst_addr), .mst_len(mst_len), .mst_ready(mst_ready),
    .mst_done(mst_done), .mst_msgs(mst_msgs), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] dir;
    logic [1:0] wresp;
    int         delay;
    int         exp_id;
  } vec_t;

  typedef struct {
    int        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        dir;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(int r, int i);
    return 32'h1000_0000 + 32'(r) * 32'h100 + 32'(i) * 4;
  endfunction

  function automatic logic [7:0] len_of(int r, int i);
    return 8'(r * 2 + i + 1);
  endfunction

  // One arbitration round: drive requests, expect a grant, handshake, complete.
  task automatic run_row(int r, vec_t v);
    exp_t e;
    bit   found;
    int   waited;
    axi4_master_msgs_t m;
    req_valid = v.valid;
    req_dir   = v.dir;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_of(r, i);
      req_len[i*8 +: 8]    = len_of(r, i);
    end
    e.id = v.exp_id; e.addr = addr_of(r, v.exp_id);
    e.len = len_of(r, v.exp_id); e.dir = v.dir[v.exp_id];
    sb.push_back(e);
    found = 0; waited = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (mst_valid) found = 1; else waited++;
    end
    if (!found) begin
      check($sformatf("r%0d_mst_valid_timeout", r), 0, 1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check($sformatf("r%0d_latency", r), 64'(waited), 0);
    check($sformatf("r%0d_grant_id", r), 64'(grant_id), 64'(e.id));
    check($sformatf("r%0d_mst_addr", r), 64'(mst_addr), 64'(e.addr));
    check($sformatf("r%0d_mst_len", r), 64'(mst_len), 64'(e.len));
    check($sformatf("r%0d_mst_dir", r), 64'(mst_dir), 64'(e.dir));
    // Stall: requesters retract and scramble their fields; command must hold.
    for (int d = 0; d < v.delay; d++) begin
      req_valid = '0;
      req_addr  = {N{32'hDEAD_BEEF}};
      req_len   = '1;
      check($sformatf("r%0d_stall_ready_%0d", r, d), 64'(req_ready), 0);
      @(negedge clk);
      check($sformatf("r%0d_stall_valid_%0d", r, d), 64'(mst_valid), 1);
      check($sformatf("r%0d_stall_addr_%0d", r, d), 64'(mst_addr), 64'(e.addr));
      check($sformatf("r%0d_stall_len_%0d", r, d), 64'(mst_len), 64'(e.len));
    end
    mst_ready = 1'b1;
    #1 check($sformatf("r%0d_req_ready", r), 64'(req_ready), 64'(1 << e.id));
    @(negedge clk);
    mst_ready = 1'b0;
    req_valid[e.id] = 1'b0;
    #1 check($sformatf("r%0d_busy_mst_valid", r), 64'(mst_valid), 0);
    check($sformatf("r%0d_busy_req_ready", r), 64'(req_ready), 0);
    check($sformatf("r%0d_busy_no_done", r), 64'(req_done), 0);
    @(negedge clk);
    m.rresp = 2'b01; m.wresp = v.wresp;
    mst_msgs = m; mst_done = 1'b1;
    #1 check($sformatf("r%0d_req_done", r), 64'(req_done), 64'(1 << e.id));
    check($sformatf("r%0d_req_msgs", r), 64'(req_msgs), 64'(m));
    @(negedge clk);
    mst_done = 1'b0;
    mst_msgs = '0;
  endtask

  vec_t tbl[9];

  initial begin
    // valid, dir, wresp, stall cycles, expected winner
    tbl[0] = '{2'b11, 2'b00, AXI4_RESP_OKAY,   0, 0};
    tbl[1] = '{2'b10, 2'b00, AXI4_RESP_OKAY,   0, 1};
    tbl[2] = '{2'b11, 2'b01, AXI4_RESP_OKAY,   0, 0};
    tbl[3] = '{2'b11, 2'b10, AXI4_RESP_EXOKAY, 0, 1};
    tbl[4] = '{2'b01, 2'b00, AXI4_RESP_OKAY,   0, 0};
    tbl[5] = '{2'b01, 2'b01, AXI4_RESP_DECERR, 0, 0};
    tbl[6] = '{2'b11, 2'b11, AXI4_RESP_SLVERR, 5, 1};
`ifdef AXI_ARB_WRITE_PRIO_EN
    tbl[7] = '{2'b11, 2'b10, AXI4_RESP_OKAY,   0, 1};
`else
    tbl[7] = '{2'b11, 2'b10, AXI4_RESP_OKAY,   0, 0};
`endif
    tbl[8] = '{2'b10, 2'b10, AXI4_RESP_OKAY,   2, 1};

    rst = 1'b1; req_valid = '0; req_dir = '0; req_addr = '0; req_len = '0;
    mst_ready = 1'b0; mst_done = 1'b0; mst_msgs = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mst_valid", 64'(mst_valid), 0);
    check("rst_grant_id", 64'(grant_id), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_req_done", 64'(req_done), 0);
    check("rst_req_msgs", 64'(req_msgs), 0);
    check("rst_mst_addr", 64'(mst_addr), 0);

    // Stray completion in IDLE is ignored.
    mst_done = 1'b1; mst_msgs = '{2'b11, 2'b11};
    #1 check("idle_stray_done", 64'(req_done), 0);
    check("idle_stray_msgs", 64'(req_msgs), 0);
    @(negedge clk);
    mst_done = 1'b0; mst_msgs = '0;

    for (int r = 0; r < 9; r++) run_row(r, tbl[r]);
    check("sb_empty", 64'(sb.size()), 0);

    // Reset in BUSY abandons the transaction.
    req_valid = 2'b10; req_dir = 2'b00;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_of(9, i);
      req_len[i*8 +: 8]    = len_of(9, i);
    end
    @(negedge clk);
    check("pre_rst_grant", 64'(grant_id), 1);
    mst_ready = 1'b1;
    @(negedge clk);
    mst_ready = 1'b0; req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("busy_rst_mst_valid", 64'(mst_valid), 0);
    check("busy_rst_grant_id", 64'(grant_id), 0);
    check("busy_rst_mst_addr", 64'(mst_addr), 0);
    check("busy_rst_mst_len", 64'(mst_len), 0);
    mst_done = 1'b1; mst_msgs = '{2'b00, AXI4_RESP_SLVERR};
    #1 check("busy_rst_late_done", 64'(req_done), 0);
    check("busy_rst_late_msgs", 64'(req_msgs), 0);
    @(negedge clk);
    mst_done = 1'b0; mst_msgs = '0;
    #1 check("busy_rst_stays_idle", 64'(mst_valid), 0);

    // Pointer restored by reset: requester 0 wins again.
    run_row(10, '{2'b11, 2'b00, AXI4_RESP_OKAY, 0, 0});
    check("sb_empty_end", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
